// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one main_memory port between NUM_CH requesters
// (round-robin or fixed priority), with tagged routing of read returns.
module mem_port_arbiter #(
  parameter int NUM_CH       = 4,
  parameter int ADDR_BITS    = 11,
  parameter int WORD_BITS    = 32,
  parameter int READ_LATENCY = 1,
  parameter int ARB_MODE     = 0
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [NUM_CH-1:0]                 ch_req,
  input  logic [NUM_CH*ADDR_BITS-1:0]       ch_addr,
  input  logic [NUM_CH*WORD_BITS-1:0]       ch_wr_data,
  input  logic [NUM_CH*(WORD_BITS/8)-1:0]   ch_wr_en,
  output logic [NUM_CH-1:0]                 ch_gnt,
  output logic [WORD_BITS-1:0]              ch_rd_data,
  output logic [NUM_CH-1:0]                 ch_rd_valid,
  output logic [ADDR_BITS-1:0]              mem_address,
  output logic [WORD_BITS-1:0]              mem_wr_data,
  output logic [WORD_BITS/8-1:0]            mem_wr_en,
  output logic                              mem_rd_en,
  input  logic [WORD_BITS-1:0]              mem_rd_data
);
  localparam int BE    = WORD_BITS / 8;
  localparam int CW    = $clog2(NUM_CH);
  localparam int DEPTH = READ_LATENCY + 1;

  logic [CW-1:0]                rr_ptr_q, rr_ptr_d, gnt_idx, cand;
  logic                         gnt_any, grant;
  logic [BE-1:0]                sel_en;
  logic [ADDR_BITS-1:0]         mem_address_q, mem_address_d;
  logic [WORD_BITS-1:0]         mem_wr_data_q, mem_wr_data_d;
  logic [BE-1:0]                mem_wr_en_q, mem_wr_en_d;
  logic                         mem_rd_en_q, mem_rd_en_d;
  logic [DEPTH-1:0]             tag_v_q, tag_v_d;
  logic [DEPTH-1:0][CW-1:0]     tag_ch_q, tag_ch_d;

  // Scan from the farthest candidate back to the nearest so the nearest requester wins.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    for (int j = NUM_CH; j >= 1; j--) begin
      cand = CW'(ARB_MODE != 0 ? j - 1 : (int'(rr_ptr_q) + j) % NUM_CH);
      if (ch_req[cand]) begin
        gnt_any = 1'b1;
        gnt_idx = cand;
      end
    end
  end

  assign grant  = reset & gnt_any;
  assign ch_gnt = grant ? NUM_CH'(1) << gnt_idx : '0;
  assign sel_en = ch_wr_en[int'(gnt_idx)*BE +: BE];

  always_comb begin
    rr_ptr_d      = grant ? gnt_idx : rr_ptr_q;
    mem_address_d = grant ? ch_addr[int'(gnt_idx)*ADDR_BITS +: ADDR_BITS] : mem_address_q;
    mem_wr_data_d = grant ? ch_wr_data[int'(gnt_idx)*WORD_BITS +: WORD_BITS] : mem_wr_data_q;
    mem_wr_en_d   = grant ? sel_en : '0;
    mem_rd_en_d   = grant && sel_en == '0;
    tag_v_d       = {tag_v_q[DEPTH-2:0], mem_rd_en_d};
    tag_ch_d      = {tag_ch_q[DEPTH-2:0], gnt_idx};
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      rr_ptr_q      <= CW'(NUM_CH - 1);
      mem_address_q <= '0;
      mem_wr_data_q <= '0;
      mem_wr_en_q   <= '0;
      mem_rd_en_q   <= 1'b0;
      tag_v_q       <= '0;
      tag_ch_q      <= '0;
    end else begin
      rr_ptr_q      <= rr_ptr_d;
      mem_address_q <= mem_address_d;
      mem_wr_data_q <= mem_wr_data_d;
      mem_wr_en_q   <= mem_wr_en_d;
      mem_rd_en_q   <= mem_rd_en_d;
      tag_v_q       <= tag_v_d;
      tag_ch_q      <= tag_ch_d;
    end
  end

  assign mem_address = mem_address_q;
  assign mem_wr_data = mem_wr_data_q;
  assign mem_wr_en   = mem_wr_en_q;
  assign mem_rd_en   = mem_rd_en_q;
  assign ch_rd_data  = mem_rd_data;
  assign ch_rd_valid = tag_v_q[DEPTH-1] ? NUM_CH'(1) << tag_ch_q[DEPTH-1] : '0;
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Parametrised N-channel arbiter that shares one port of main_memory between several GPU-side requesters.
- Requesters include the DisplayProcessor data path, a palette/framebuffer DMA and the host loader.
- Successor to the fixed two-port arrangement, where port A serves instructions and port B serves data.
- Adds round-robin or fixed-priority arbitration, byte-enable writes and tagged read-return routing for a configurable memory read latency.

Parameters:
- NUM_CH, 4, number of requester channels (2..8).
- ADDR_BITS, 11, word-address/byte-address width, matching $clog2(MAIN_MEMORY_BYTES).
- WORD_BITS, 32, data width; must be a multiple of 8.
- READ_LATENCY, 1, memory cycles from sampled read to valid mem_rd_data (1..4).
- ARB_MODE, 0, 0 = round-robin, 1 = fixed priority with channel 0 highest.

Ports:
- clk  in  1  single clock for everything.
- reset  in  1  synchronous, active-low; 0 = reset.
- ch_req  in  NUM_CH  per-channel request; held high with stable payload until granted.
- ch_addr  in  NUM_CH*ADDR_BITS  flattened addresses; channel i at [i*ADDR_BITS +: ADDR_BITS].
- ch_wr_data  in  NUM_CH*WORD_BITS  flattened write data.
- ch_wr_en  in  NUM_CH*(WORD_BITS/8)  byte enables; all-zero means read.
- ch_gnt  out  NUM_CH  one-hot grant; at most one bit high per cycle.
- ch_rd_data  out  WORD_BITS  shared read-return data.
- ch_rd_valid  out  NUM_CH  one-hot; pulses with the owning channel's read data.
- mem_address  out  ADDR_BITS  to main_memory port address.
- mem_wr_data  out  WORD_BITS  to main_memory port write data.
- mem_wr_en  out  WORD_BITS/8  to main_memory byte write enables.
- mem_rd_en  out  1  to main_memory port read enable.
- mem_rd_data  in  WORD_BITS  from main_memory.

Behaviour:
- **Reset** (reset==0 at a rising edge):
  - rr_ptr <= NUM_CH-1, so channel 0 has first priority.
  - mem_address, mem_wr_data, mem_wr_en and mem_rd_en are cleared to 0.
  - The tag pipeline is cleared, so ch_rd_valid = 0.
  - ch_gnt is forced to 0 combinationally while reset==0.
- **Arbitration** (combinational, cycle N):
  - ARB_MODE 0: scan channels starting at rr_ptr+1, modulo NUM_CH; the first requester wins.
  - ARB_MODE 1: the lowest-index requester wins.
  - ch_gnt[i] high in cycle N means the request is consumed at the edge ending N. The requester may change its payload or drop ch_req in N+1.
- **Pointer update:** rr_ptr <= granted index, only in cycles with a grant; otherwise it holds.
- **Issue:** at the edge ending N, the granted channel's address, data and byte enables are registered onto mem_*.
  - mem_rd_en = 1 only for reads; writes drive mem_rd_en = 0.
  - With no grant, mem_wr_en = 0 and mem_rd_en = 0; address/data hold their last values.
- **Throughput:** one access per cycle. A sole requester is granted every cycle (back-to-back).
- **Read return:**
  - A tag {valid, channel} enters a shift pipeline of depth READ_LATENCY+1 at the issue edge.
  - The output aligns with mem_rd_data: for READ_LATENCY=1, a read granted in N returns in N+2.
  - ch_rd_data = mem_rd_data, passed through unregistered.
  - ch_rd_valid[tag.ch] = tag.valid. Writes produce no tag.
- **Ordering:** returns are in issue order; there is no reordering.
- **Write→read same address:** issue order is preserved, and a read issued after a write sees the new data (main_memory semantics).
- **Invalid requests:** ch_req deasserted before grant is legal and is simply dropped. The payload of an ungranted request is ignored.
- **Reset mid-operation:** in-flight read tags are discarded; no ch_rd_valid pulses after reset even if memory returns data.
- **Width rules:** byte enables are passed through unmodified. A partial-enable write is a write; mem_rd_en = 0.

Test Plan:
- **Reset:** hold reset=0 for 3 cycles with all ch_req=1 → ch_gnt=0, mem_wr_en=0, mem_rd_en=0, ch_rd_valid=0. First cycle after release → ch_gnt=4'b0001.
- **Round-robin fairness** (ARB_MODE 0, NUM_CH 4): all 4 channels request continuously for 8 cycles → grants 0,1,2,3,0,1,2,3; no channel waits more than 3 cycles.
- **Fixed priority** (ARB_MODE 1): ch0 and ch2 request continuously → ch0 granted every cycle, ch2 starved. Drop ch0 → ch2 granted the next cycle.
- **Write then read:**
  - ch1 writes 0xDEADBEEF to addr 0x10 with byte enables 4'hF.
  - ch3 reads 0x10 in the next cycle; READ_LATENCY=1, read granted in N → ch_rd_valid=4'b1000 in N+2 with ch_rd_data=0xDEADBEEF.
  - A partial write of 0x000000AA with enables 4'h1, then a read → 0xDEADBEAA.
- **Latency/routing sweep** (READ_LATENCY 3): interleaved reads from ch0 (addr 4) and ch2 (addr 8) on consecutive cycles → valids arrive 4 cycles after each grant, in order, each routed to the correct channel with the matching preloaded data.
- **Reset mid-flight:** issue 2 reads, then assert reset=0 for 1 cycle before the returns → no ch_rd_valid pulses. rr_ptr restored: all requesting → ch0 granted first.
